// File: rtl/serial_bit_feeder_if.sv
// serial_bit_feeder_if: word handshake in, serial bit stream out, for serial_bit_feeder
interface serial_bit_feeder_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic din_ready;
  logic x;
  logic x_valid;
  logic last;
  logic busy;
  modport master (output din, din_valid, input din_ready, x, x_valid, last, busy);
  modport slave (input din, din_valid, output din_ready, x, x_valid, last, busy);
endinterface

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: WIDTH-bit words in, one bit per clk out MSB first, zero-bubble back-to-back.
// Define SERIAL_PARITY_EN to append an even-parity bit after each word's LSB.
module serial_bit_feeder #(
  parameter int WIDTH = 8,
  parameter bit IDLE_BIT = 1'b0
) (
  input logic clk,
  input logic rst_n,
  serial_bit_feeder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
`ifdef SERIAL_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic par_q, par_d;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept, last;
  always_comb begin
`ifdef SERIAL_PARITY_EN
    last = state_q == PARITY;
`else
    last = state_q == SHIFT && cnt_q == '0;
`endif
    bus.din_ready = state_q == IDLE || last;
    accept = bus.din_valid && bus.din_ready;
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d = cnt_q;
`ifdef SERIAL_PARITY_EN
    par_d = par_q;
`endif
    if (accept) begin
      state_d = SHIFT;
      shreg_d = bus.din;
      cnt_d = CW'(WIDTH - 1);
`ifdef SERIAL_PARITY_EN
      par_d = ^bus.din;
`endif
    end else if (state_q == SHIFT) begin
      shreg_d = shreg_q << 1;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
`ifdef SERIAL_PARITY_EN
      state_d = cnt_q == '0 ? PARITY : SHIFT;
`else
      state_d = cnt_q == '0 ? IDLE : SHIFT;
`endif
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q <= '0;
`ifdef SERIAL_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
`ifdef SERIAL_PARITY_EN
      par_q <= par_d;
`endif
    end
  // serial outputs depend only on registered state, never on din/din_valid
`ifdef SERIAL_PARITY_EN
  assign bus.x = state_q == SHIFT ? shreg_q[WIDTH-1] : state_q == PARITY ? par_q : IDLE_BIT;
`else
  assign bus.x = state_q == SHIFT ? shreg_q[WIDTH-1] : IDLE_BIT;
`endif
  assign bus.x_valid = state_q != IDLE;
  assign bus.last = last;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: directed checks of the serial feeder, incl. a 101 overlapping detector model
module tb_serial_bit_feeder;
`ifdef SERIAL_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  serial_bit_feeder_if #(.WIDTH(8)) bus ();
  serial_bit_feeder #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input int i);
    return i < 8 ? w[7-i] : ^w;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_x"}, 32'(bus.x), 32'd0);
    chk({tag, "_xv"}, 32'(bus.x_valid), 32'd0);
    chk({tag, "_last"}, 32'(bus.last), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rdy"}, 32'(bus.din_ready), 32'd1);
  endtask

  task automatic run_word(input logic [7:0] w, input string tag);
    bus.din = w;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    bus.din = 8'h00;
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s_x%0d", tag, i), 32'(bus.x), 32'(exp_bit(w, i)));
      chk($sformatf("%s_xv%0d", tag, i), 32'(bus.x_valid), 32'd1);
      chk($sformatf("%s_last%0d", tag, i), 32'(bus.last), 32'(i == NB - 1));
      tick();
    end
    check_idle({tag, "_end"});
  endtask

  initial begin
    logic [15:0] pair;
    logic [1:0] h;
    logic z;
    bus.din = 8'h00;
    bus.din_valid = 1'b0;
    #12;
    check_idle("rst");
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");
    // T1: single word
    run_word(8'b1010_0101, "t1");
    // T2: two back-to-back words, valid held
    pair = 16'hA53C;
    bus.din = 8'hA5;
    bus.din_valid = 1'b1;
    tick();
    bus.din = 8'h3C;
    for (int i = 0; i < 2 * NB; i++) begin
      if (i == NB) bus.din_valid = 1'b0;
      chk($sformatf("t2_x%0d", i), 32'(bus.x),
          32'(exp_bit(i < NB ? pair[15:8] : pair[7:0], i % NB)));
      chk($sformatf("t2_xv%0d", i), 32'(bus.x_valid), 32'd1);
      chk($sformatf("t2_rdy%0d", i), 32'(bus.din_ready), 32'(i == NB - 1 || i == 2 * NB - 1));
      tick();
    end
    check_idle("t2_end");
    // T3: din churns while busy and not last
    bus.din = 8'hC3;
    bus.din_valid = 1'b1;
    tick();
    for (int i = 0; i < NB; i++) begin
      bus.din = 8'(i * 37 + 5);
      if (i == NB - 1) bus.din_valid = 1'b0;
      #1;
      chk($sformatf("t3_x%0d", i), 32'(bus.x), 32'(exp_bit(8'hC3, i)));
      chk($sformatf("t3_rdy%0d", i), 32'(bus.din_ready), 32'(i == NB - 1));
      tick();
    end
    check_idle("t3_end");
    // T4: async reset mid-word
    bus.din = 8'hFF;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_pre_xv", 32'(bus.x_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("t4_rst");
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("t4_rel");
    run_word(8'b1000_0001, "t4_next");
    // T5: overlapping 101 detector on the serial stream
    h = 2'b00;
    bus.din = 8'b0101_0100;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      z = h == 2'b10 && bus.x === 1'b1;
      chk($sformatf("t5_x%0d", i), 32'(bus.x), 32'(exp_bit(8'b0101_0100, i)));
      chk($sformatf("t5_z%0d", i), 32'(z), 32'(i == 3 || i == 5));
      h = {h[0], bus.x};
      tick();
    end
    for (int i = 8; i < NB; i++) tick();
    check_idle("t5_end");
`ifdef SERIAL_PARITY_EN
    // T6: parity bit appended
    run_word(8'b1011_0000, "t6a");
    run_word(8'h00, "t6b");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
